// File: rtl/i2s_tx_mono_if.sv
// Sample input and serial I2S output bundle for i2s_tx_mono.
// master = sample producer / line observer, slave = the transmitter.
interface i2s_tx_mono_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_din;
  logic        frame_start;
  logic        underrun;
  logic        overrun;

  modport master (
    output sample_in, sample_valid,
    input  i2s_bclk, i2s_lrclk, i2s_din, frame_start, underrun, overrun
  );

  modport slave (
    input  sample_in, sample_valid,
    output i2s_bclk, i2s_lrclk, i2s_din, frame_start, underrun, overrun
  );
endinterface

// File: rtl/i2s_tx_mono.sv
// Mono I2S transmitter: one 16-bit sample repeated in both slots of a 64-BCLK frame,
// free-running frame timing with a hold/shadow pair and sticky under/overrun flags.
module i2s_tx_mono #(
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  i2s_tx_mono_if.slave   bus
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0]  div_q, div_d;
  logic        bclk_q, bclk_d;
  logic        lrclk_q, lrclk_d;
  logic        din_q, din_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        frame_start_q, frame_start_d;
  logic        underrun_q, underrun_d;
  logic        overrun_q, overrun_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        first_q, first_d;

  logic        wrap, fall, load;
  logic [5:0]  cnt_nx;
  logic [4:0]  slot_pos;

  always_comb begin
    wrap     = (div_q == DIV_MAX);
    fall     = wrap & bclk_q;
    cnt_nx   = cnt_q + 6'd1;
    load     = fall && (cnt_nx == 6'd0);
    // One-BCLK I2S delay: counts 1..16 and 33..48 map to positions 0..15 of each slot
    slot_pos = cnt_nx[4:0] - 5'd1;

    div_d         = wrap ? 8'd0 : div_q + 8'd1;
    bclk_d        = wrap ? ~bclk_q : bclk_q;
    cnt_d         = cnt_q;
    lrclk_d       = lrclk_q;
    din_d         = din_q;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;
    overrun_d     = overrun_q;
    hold_d        = hold_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    first_d       = first_q;

    if (fall) begin
      cnt_d   = cnt_nx;
      lrclk_d = cnt_nx[5];
      din_d   = ~slot_pos[4] & shadow_q[~slot_pos[3:0]];
    end

    if (load) begin
      shadow_d      = hold_q;
      pending_d     = 1'b0;
      frame_start_d = 1'b1;
      first_d       = 1'b0;
      if (!pending_q && !first_q) underrun_d = 1'b1;
    end

    // A sample arriving in the load clk lands after the load and is not an overrun
    if (bus.sample_valid) begin
      hold_d    = bus.sample_in;
      pending_d = 1'b1;
      if (pending_q && !load) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      din_q         <= 1'b0;
      cnt_q         <= 6'd63;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
      hold_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      first_q       <= 1'b1;
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      din_q         <= din_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
      hold_q        <= hold_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      first_q       <= first_d;
    end
  end

  assign bus.i2s_bclk    = bclk_q;
  assign bus.i2s_lrclk   = lrclk_q;
  assign bus.i2s_din     = din_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underrun    = underrun_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_tx_mono.sv
// Directed bench for i2s_tx_mono: one instance at CLK_DIV=4, one at CLK_DIV=1.
module tb_i2s_tx_mono;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   fails  = 0;

  localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

  i2s_tx_mono_if ifa ();
  i2s_tx_mono_if ifb ();

  i2s_tx_mono #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  i2s_tx_mono #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bclk(input int d); return d == 0 ? ifa.i2s_bclk : ifb.i2s_bclk; endfunction
  function automatic logic lr(input int d);   return d == 0 ? ifa.i2s_lrclk : ifb.i2s_lrclk; endfunction
  function automatic logic din(input int d);  return d == 0 ? ifa.i2s_din : ifb.i2s_din; endfunction
  function automatic logic fs(input int d);   return d == 0 ? ifa.frame_start : ifb.frame_start; endfunction
  function automatic logic [1:0] flags(input int d);
    return d == 0 ? {ifa.underrun, ifa.overrun} : {ifb.underrun, ifb.overrun};
  endfunction
  function automatic logic [5:0] outs(input int d);
    return {bclk(d), lr(d), din(d), fs(d), flags(d)};
  endfunction

  function automatic logic [63:0] exp_din(input logic [15:0] s);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w[1 + i]  = s[15 - i];
      w[33 + i] = s[15 - i];
    end
    return w;
  endfunction

  task automatic drv(input int d, input logic v, input logic [15:0] s);
    if (d == 0) begin ifa.sample_valid = v; ifa.sample_in = s; end
    else        begin ifb.sample_valid = v; ifb.sample_in = s; end
  endtask

  // Counts clk edges until frame_start is seen; -1 if it never comes.
  task automatic wait_start(input int d, output int n);
    n = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (fs(d)) begin n = k; break; end
    end
  endtask

  // Called just after a frame_start; records din/lrclk per bit count and ends
  // just after the next frame_start. Optional strobes at clk 10, 20 and in the load clk.
  task automatic capture(input int d, input int per, input int nstb,
                         input logic [15:0] v1, input logic [15:0] v2,
                         input logic ld_stb, input logic [15:0] v3,
                         output logic [63:0] dw, output logic [63:0] lw,
                         output int clks, output int lr_hi);
    int   cnt;
    logic pb;
    dw = '0; lw = '0;
    dw[0] = din(d); lw[0] = lr(d);
    cnt = 0; clks = 0; lr_hi = 0; pb = bclk(d);
    for (int k = 1; k <= per + 16; k++) begin
      if (k == 10 && nstb >= 1)      drv(d, 1'b1, v1);
      else if (k == 20 && nstb >= 2) drv(d, 1'b1, v2);
      else if (k == per && ld_stb)   drv(d, 1'b1, v3);
      else                           drv(d, 1'b0, 16'h0);
      tick();
      clks = k;
      if (fs(d)) break;
      lr_hi += int'(lr(d));
      if (pb && !bclk(d)) begin
        cnt++;
        if (cnt < 64) begin dw[cnt] = din(d); lw[cnt] = lr(d); end
      end
      pb = bclk(d);
    end
    drv(d, 1'b0, 16'h0);
  endtask

  initial begin
    logic [63:0] dw, lw;
    int clks, lr_hi, n, falls;
    logic pb;

    rst_a = 1'b1; rst_b = 1'b1;
    drv(0, 1'b0, 16'h0); drv(1, 1'b0, 16'h0);
    repeat (3) tick();
    chk("reset_outputs", 64'(outs(0)), 64'h0);

    // No samples: timing, idle line, underrun at the second frame
    rst_a = 1'b0;
    wait_start(0, n);
    chk("first_start_latency", 64'(n), 64'd8);
    chk("first_load_no_underrun", 64'(flags(0)), 64'b00);
    capture(0, 512, 0, 16'h0, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("idle_din", dw, 64'h0);
    chk("idle_lrclk", lw, LR_EXP);
    chk("frame_period", 64'(clks), 64'd512);
    chk("lrclk_high_clks", 64'(lr_hi), 64'd256);
    chk("underrun_second_frame", 64'(flags(0)), 64'b10);

    // Single sample, slot duplication, then overwrite within a frame
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    chk("reset_clears_underrun", 64'(flags(0)), 64'b00);
    wait_start(0, n);
    chk("restart_latency", 64'(n), 64'd8);
    capture(0, 512, 1, 16'h8001, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("zero_frame_din", dw, 64'h0);
    chk("no_flags_after_sample", 64'(flags(0)), 64'b00);
    capture(0, 512, 1, 16'h1111, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("pattern_8001", dw, exp_din(16'h8001));
    chk("pattern_8001_lrclk", lw, LR_EXP);
    chk("no_underrun_after_8001", 64'(flags(0)), 64'b00);
    capture(0, 512, 2, 16'h1234, 16'h5678, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("pattern_1111", dw, exp_din(16'h1111));
    chk("overrun_set", 64'(flags(0)), 64'b01);
    capture(0, 512, 0, 16'h0, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("newest_sample_5678", dw, exp_din(16'h5678));

    // Mid-frame reset at bit count 20
    falls = 0; pb = bclk(0);
    for (int k = 0; k < 400 && falls < 20; k++) begin
      tick();
      if (pb && !bclk(0)) falls++;
      pb = bclk(0);
    end
    chk("reached_count_20", 64'(falls), 64'd20);
    rst_a = 1'b1; tick();
    chk("midframe_reset_outputs", 64'(outs(0)), 64'h0);
    rst_a = 1'b0;
    wait_start(0, n);
    chk("midframe_restart_latency", 64'(n), 64'd8);

    // Sample in the exact load clk while another is pending
    capture(0, 512, 1, 16'h0F0F, 16'h0, 1'b1, 16'hAAAA, dw, lw, clks, lr_hi);
    chk("load_clk_strobe_period", 64'(clks), 64'd512);
    chk("load_clk_no_overrun", 64'(flags(0)), 64'b00);
    capture(0, 512, 0, 16'h0, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("pattern_0f0f", dw, exp_din(16'h0F0F));
    chk("flags_after_0f0f", 64'(flags(0)), 64'b00);
    capture(0, 512, 0, 16'h0, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("pattern_aaaa", dw, exp_din(16'hAAAA));

    // CLK_DIV = 1 instance
    tick(); rst_b = 1'b0;
    wait_start(1, n);
    chk("div1_first_start", 64'(n), 64'd2);
    capture(1, 128, 1, 16'h8001, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("div1_period", 64'(clks), 64'd128);
    chk("div1_zero_frame", dw, 64'h0);
    capture(1, 128, 0, 16'h0, 16'h0, 1'b0, 16'h0, dw, lw, clks, lr_hi);
    chk("div1_pattern_8001", dw, exp_din(16'h8001));
    chk("div1_lrclk", lw, LR_EXP);
    chk("div1_lrclk_high_clks", 64'(lr_hi), 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx_mono.md
I2S_TX_MONO -- requirements
Module: i2s_tx_mono

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk cycles per BCLK half-period; legal range 1..255.
REQ-002 Port: clk  input  1  system clock (25 MHz); the single clock for all logic.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: sample_in  input  16  signed PCM sample from the CIC decimator.
REQ-005 Port: sample_valid  input  1  one-clk strobe qualifying sample_in; no backpressure.
REQ-006 Port: i2s_bclk  output  1  serial bit clock.
REQ-007 Port: i2s_lrclk  output  1  word select: 0 = left slot, 1 = right slot.
REQ-008 Port: i2s_din  output  1  serial data, MSB first.
REQ-009 Port: frame_start  output  1  one-clk pulse when a new frame begins (shadow load).
REQ-010 Port: underrun  output  1  sticky: a frame began with no new sample since the previous load.
REQ-011 Port: overrun  output  1  sticky: a held sample was overwritten before being loaded.

Function
REQ-012 Divider counter runs 0..CLK_DIV-1; i2s_bclk toggles on each wrap, giving a BCLK period of 2*CLK_DIV clk cycles.
REQ-013 A BCLK falling transition is the clk in which i2s_bclk goes 1->0; i2s_lrclk, i2s_din and the bit counter update in that same clk, all registered outputs.
REQ-014 Bit counter is 6 bits and advances 0..63 on each falling transition, wrapping 63->0; one frame = 64 BCLK = 128*CLK_DIV clk cycles (512 at default, 48.83 kHz at 25 MHz).
REQ-015 i2s_lrclk = 0 for bit counts 0..31 and 1 for bit counts 32..63.
REQ-016 Standard I2S one-BCLK delay: i2s_din carries shadow[15..0] at counts 1..16 (left) and again at counts 33..48 (right); all other counts drive 0.
REQ-017 Mono duplication: both slots carry the same shadow value.
REQ-018 Holding register: on sample_valid, sample_in is captured into hold and the pending flag is set.
REQ-019 At the falling transition entering count 0, shadow <= hold, pending is cleared, and frame_start pulses high for exactly that clk.
REQ-020 If pending = 0 at the load, shadow is reloaded with the unchanged hold value (last sample repeats) and underrun is set.
REQ-021 If sample_valid arrives while pending = 1, hold is overwritten with the newer sample and overrun is set.
REQ-022 If sample_valid coincides with the load clk, the load uses the old hold, then the new sample is captured and pending = 1 afterward; this case does not set overrun.
REQ-023 underrun and overrun clear only on rst.
REQ-024 Frame phase is free-running and never resynchronises to sample_valid.

Reset
REQ-025 While rst = 1: divider = 0, i2s_bclk = 0, i2s_lrclk = 0, i2s_din = 0, frame_start = 0, underrun = 0, overrun = 0, hold = 0, shadow = 0, pending = 0, and the bit counter = 63.
REQ-026 After rst deasserts, the first falling transition occurs 2*CLK_DIV clks later, enters count 0, and performs a load. That first load does not set underrun.
REQ-027 Asserting rst mid-frame aborts the frame immediately. All state returns to REQ-025 values in the next clk; no partial word is completed.

Verification
REQ-028 Reset release, CLK_DIV = 4, no samples -> first frame_start 8 clks after release; frame_start period 512 clks; i2s_din constantly 0; i2s_lrclk high for 256 clks per frame; underrun set at the second frame_start.
REQ-029 sample 0x8001 strobed once before a load -> left slot bits at counts 1..16 read 1,0,0,...,0,1, and the right slot is identical. Counts 17..32 and 49..0 read 0; underrun stays 0 for that frame.
REQ-030 Two strobes, 0x1234 then 0x5678, within one frame -> next frame serialises 0x5678 in both slots; overrun = 1; underrun = 0.
REQ-031 sample_valid in the exact load clk with 0xAAAA, with hold = 0x0F0F pending -> current frame sends 0x0F0F; the next frame sends 0xAAAA; overrun stays 0.
REQ-032 rst pulsed for 1 clk at bit count 20 -> outputs equal reset values the next clk; frame timing restarts per REQ-026; sticky flags cleared.
REQ-033 CLK_DIV = 1 -> BCLK period 2 clks and frame period 128 clks; the 0x8001 pattern of REQ-029 is reproduced exactly.
